// File: rtl/plrut_ctrl.sv
// plrut_ctrl: 4-way tree-PLRU controller; CPU touch/allocate and bus invalidate arbitrated round-robin onto a 1-cycle-latency PLRU RAM (clk, rst_n, cpu_*/bus_* request/ack, ready, ram_r_*/ram_w_*)
module plrut_ctrl #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_set,
  input  logic [1:0]            cpu_way,
  input  logic                  cpu_op,
  output logic                  cpu_ack,
  output logic [1:0]            cpu_victim,
  input  logic                  bus_req,
  input  logic [ADDR_WIDTH-1:0] bus_set,
  input  logic [1:0]            bus_way,
  output logic                  bus_ack,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [2:0]            ram_r_plrut,
  output logic                  ram_w_en,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [2:0]            ram_w_plrut
);
  typedef enum logic [1:0] {INIT, IDLE, UPD} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, op_set;
  logic [1:0] op_way, vict, tgt;
  logic [2:0] fwd_tree, base, new_tree;
  logic op_bus, op_alloc, prio_bus, fwd, in_upd, gnt_bus, gnt_cpu, b0, leaf;
  always_ff @(posedge clk)
    if (!rst_n) state <= INIT;
    else state <= state_nxt;
  always_comb begin
    in_upd = rst_n && state == UPD;
    ready = rst_n && state != INIT;
    cpu_ack = in_upd && !op_bus;
    bus_ack = in_upd && op_bus;
    gnt_bus = ready && bus_req && !bus_ack && (prio_bus || !cpu_req || cpu_ack);
    gnt_cpu = ready && cpu_req && !cpu_ack && !gnt_bus;
    base = fwd ? fwd_tree : ram_r_plrut;
    vict = base[0] ? {1'b1, base[2]} : {1'b0, base[1]};
    tgt = (op_bus || !op_alloc) ? op_way : vict;
    // touch points the tree away from the way, invalidate points it at the way
    b0 = tgt[1] ^ !op_bus;
    leaf = tgt[0] ^ !op_bus;
    new_tree = tgt[1] ? {leaf, base[1], b0} : {base[2], leaf, b0};
    ram_r_addr = gnt_bus ? bus_set : gnt_cpu ? cpu_set : '0;
    ram_w_en = rst_n && (state == INIT || state == UPD);
    ram_w_addr = !rst_n ? '0 : state == INIT ? cnt : op_set;
    ram_w_plrut = in_upd ? new_tree : '0;
    cpu_victim = cpu_ack ? vict : '0;
    state_nxt = state == INIT ? (cnt == '1 ? IDLE : INIT) : (gnt_bus || gnt_cpu) ? UPD : IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      prio_bus <= 1'b1;
      fwd <= 1'b0;
    end else begin
      cnt <= state == INIT ? cnt + 1'b1 : '0;
      if (gnt_bus || gnt_cpu) begin
        prio_bus <= gnt_cpu;
        op_bus <= gnt_bus;
        op_set <= ram_r_addr;
        op_way <= gnt_bus ? bus_way : cpu_way;
        op_alloc <= gnt_cpu && cpu_op;
      end
      // the RAM returns pre-write data when the next op hits the set being written now
      fwd <= state == UPD && (gnt_bus || gnt_cpu) && ram_r_addr == op_set;
      fwd_tree <= new_tree;
    end
endmodule
